// File: rtl/board_tx_scanner_if.sv
// Board-scanner bus: start/status handshake, board read port and UART line.
interface board_tx_scanner_if;
  logic       iniciar;
  logic [3:0] addr_macro;
  logic [3:0] addr_micro;
  logic [1:0] cell_data;
  logic       tx;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  // scanner side
  modport master (
    input  iniciar, cell_data,
    output addr_macro, addr_micro, tx, ocupado, pronto, db_estado
  );

  // control unit / board RAM / line side
  modport slave (
    output iniciar, cell_data,
    input  addr_macro, addr_micro, tx, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/board_tx_scanner.sv
// Scans the 9x9 board in visual row-major order and sends it as an ASCII grid
// over an 8N1 serial line, CR+LF after every visual row (99 bytes per frame).
module board_tx_scanner #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                clock,
  input  logic                reset,
  board_tx_scanner_if.master  bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ADDR = 3'd1, S_WAIT = 3'd2, S_SEND = 3'd3,
    S_NEXT = 3'd4, S_CR   = 3'd5, S_LF   = 3'd6, S_DONE = 3'd7
  } state_t;

  // what the byte currently on the line was, steering the NEXT decision
  typedef enum logic [1:0] {K_CELL = 2'd0, K_CR = 2'd1, K_LF = 2'd2} kind_t;

  state_t        state;
  kind_t         kind;
  logic [1:0]    mr, ur, mc, uc;
  logic [1:0]    mr_n, ur_n, mc_n, uc_n;
  logic [3:0]    addr_macro, addr_micro;
  logic [7:0]    shreg;
  logic [3:0]    bit_idx;
  logic [CW-1:0] clk_cnt;
  logic          tx, ocupado, pronto;

  function automatic logic [7:0] cell_char(input logic [1:0] c);
    case (c)
      2'b00:   return 8'h2E;
      2'b01:   return 8'h58;
      2'b10:   return 8'h4F;
      default: return 8'h23;
    endcase
  endfunction

  function automatic logic [3:0] addr3(input logic [1:0] hi, input logic [1:0] lo);
    return {2'b00, hi} * 4'd3 + {2'b00, lo};
  endfunction

  // Counter advance: after a cell step uc (carry into mc); after LF restart
  // the row and step ur (carry into mr). Only used when no wrap-out is due.
  always_comb begin
    mr_n = mr;
    ur_n = ur;
    mc_n = mc;
    uc_n = uc;
    if (kind == K_CELL) begin
      if (uc == 2'd2) begin
        uc_n = 2'd0;
        mc_n = mc + 2'd1;
      end else begin
        uc_n = uc + 2'd1;
      end
    end else begin
      uc_n = 2'd0;
      mc_n = 2'd0;
      if (ur == 2'd2) begin
        ur_n = 2'd0;
        mr_n = mr + 2'd1;
      end else begin
        ur_n = ur + 2'd1;
      end
    end
  end

  // Scan/transmit FSM with registered addresses and line outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      kind       <= K_CELL;
      mr         <= '0;
      ur         <= '0;
      mc         <= '0;
      uc         <= '0;
      addr_macro <= '0;
      addr_micro <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      clk_cnt    <= '0;
      tx         <= 1'b1;
      ocupado    <= 1'b0;
      pronto     <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (state)
        S_IDLE: if (bus.iniciar) begin
          mr         <= '0;
          ur         <= '0;
          mc         <= '0;
          uc         <= '0;
          addr_macro <= '0;
          addr_micro <= '0;
          ocupado    <= 1'b1;
          state      <= S_ADDR;
        end
        S_ADDR: state <= S_WAIT;
        // RAM output is valid now, one cycle after the address settled
        S_WAIT, S_CR, S_LF: begin
          if (state == S_WAIT) begin
            shreg <= cell_char(bus.cell_data);
            kind  <= K_CELL;
          end else if (state == S_CR) begin
            shreg <= 8'h0D;
            kind  <= K_CR;
          end else begin
            shreg <= 8'h0A;
            kind  <= K_LF;
          end
          tx      <= 1'b0;
          bit_idx <= '0;
          clk_cnt <= '0;
          state   <= S_SEND;
        end
        // bit_idx 0 is the start bit; ones shifted in behind the data
        // become the stop bit after the eighth shift
        S_SEND: begin
          if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd9) begin
              state <= S_NEXT;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b1, shreg[7:1]};
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_NEXT: begin
          case (kind)
            K_CELL: begin
              if (uc == 2'd2 && mc == 2'd2) begin
                state <= S_CR;
              end else begin
                {mr, ur, mc, uc} <= {mr_n, ur_n, mc_n, uc_n};
                addr_macro       <= addr3(mr_n, mc_n);
                addr_micro       <= addr3(ur_n, uc_n);
                state            <= S_ADDR;
              end
            end
            K_CR: state <= S_LF;
            default: begin
              if (mr == 2'd2 && ur == 2'd2) begin
                ocupado <= 1'b0;
                pronto  <= 1'b1;
                state   <= S_DONE;
              end else begin
                {mr, ur, mc, uc} <= {mr_n, ur_n, mc_n, uc_n};
                addr_macro       <= addr3(mr_n, mc_n);
                addr_micro       <= addr3(ur_n, uc_n);
                state            <= S_ADDR;
              end
            end
          endcase
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.addr_macro = addr_macro;
  assign bus.addr_micro = addr_micro;
  assign bus.tx         = tx;
  assign bus.ocupado    = ocupado;
  assign bus.pronto     = pronto;
  assign bus.db_estado  = state;
endmodule

// File: tb/tb_board_tx_scanner.sv
// Bench for board_tx_scanner: board RAM model, UART decoder, scoreboard.
module tb_board_tx_scanner;
  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  board_tx_scanner_if bus();

  board_tx_scanner #(.CLKS_PER_BIT(CPB)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // board RAM, one-cycle read latency
  logic [1:0] board [0:8][0:8];
  always @(posedge clk) begin
    if (bus.addr_macro < 4'd9 && bus.addr_micro < 4'd9)
      bus.cell_data <= board[bus.addr_macro][bus.addr_micro];
    else
      bus.cell_data <= 2'b00;
  end

  typedef struct {
    logic [7:0] b;
    int          idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] char_of [0:3] = '{8'h2E, 8'h58, 8'h4F, 8'h23};
  logic [7:0] rx_frame [0:98];
  int checks = 0, errors = 0;
  int rx_idx = 0, rx_total = 0, exp_total = 0;
  int prev_start = 0, exp_t0 = 0, pronto_cnt = 0, addr_bad = 0;
  logic prev_ocu = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Expected frame straight from the grid definition: visual (row, col)
  // maps to macro = 3*(row/3)+col/3, micro = 3*(row%3)+col%3.
  task automatic push_frame();
    exp_t e;
    int   n = 0;
    for (int vr = 0; vr < 9; vr++) begin
      for (int vc = 0; vc < 9; vc++) begin
        e.b   = char_of[board[3*(vr/3) + vc/3][3*(vr%3) + vc%3]];
        e.idx = n++;
        exp_q.push_back(e);
      end
      e.b = 8'h0D; e.idx = n++; exp_q.push_back(e);
      e.b = 8'h0A; e.idx = n++; exp_q.push_back(e);
    end
    exp_total += 99;
  endtask

  task automatic got_byte(input logic [7:0] b, input logic ok, input int start);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected byte: got %0h expected none (cycle %0d)", b, cyc);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("byte[%0d]", e.idx), b, e.b);
      check("framing", ok, 1);
      if (e.idx == 0)
        check("first start bit time", start, exp_t0);
      else
        check($sformatf("start gap[%0d]", e.idx), start - prev_start,
              (e.b == 8'h0D || e.b == 8'h0A) ? 42 : 43);
      prev_start = start;
      rx_frame[e.idx] = b;
      rx_idx = e.idx + 1;
    end
    rx_total++;
  endtask

  // UART decoder: mid-bit sampling from the first low cycle
  initial begin
    logic       busy = 1'b0, ok = 1'b1;
    logic [7:0] data = '0;
    int         off = 0, start = 0, k;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
      end else if (!busy) begin
        if (bus.tx === 1'b0) begin
          busy = 1'b1; off = 0; start = cyc; ok = 1'b1; data = '0;
        end
      end else begin
        off++;
        if (off % CPB == CPB/2) begin
          k = off / CPB;
          if (k == 0)      ok = ok & (bus.tx === 1'b0);
          else if (k <= 8) data[k-1] = bus.tx;
          else begin
            ok   = ok & (bus.tx === 1'b1);
            busy = 1'b0;
            got_byte(data, ok, start);
          end
        end
      end
    end
  end

  // completion/status monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.addr_macro > 4'd8 || bus.addr_micro > 4'd8) addr_bad++;
        if (bus.pronto === 1'b1) begin
          pronto_cnt++;
          check("ocupado falls with pronto", {bus.ocupado, prev_ocu}, 2'b01);
          check("queue empty at pronto", exp_q.size(), 0);
          check("frame length", rx_idx, 99);
        end
      end
      prev_ocu = bus.ocupado;
    end
  end

  task automatic start_frame();
    push_frame();
    rx_idx = 0;
    pronto_cnt = 0;
    @(posedge clk); #1;
    exp_t0 = cyc + 3;
    bus.iniciar = 1'b1;
    @(posedge clk); #1;
    bus.iniciar = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (pronto_cnt == 0 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    if (pronto_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL frame timeout: got no pronto expected pronto within 6000 cycles");
    end
    repeat (10) @(posedge clk);
    check("pronto pulses per frame", pronto_cnt, 1);
  endtask

  task automatic wait_idx(input int k);
    int n = 0;
    while (rx_idx < k && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (rx_idx < k) begin
      checks++;
      errors++;
      $display("FAIL byte wait timeout: got %0d bytes expected %0d", rx_idx, k);
    end
  endtask

  task automatic clear_board();
    for (int m = 0; m < 9; m++)
      for (int u = 0; u < 9; u++) board[m][u] = 2'b00;
  endtask

  task automatic rand_board();
    for (int m = 0; m < 9; m++)
      for (int u = 0; u < 9; u++) board[m][u] = 2'($urandom_range(0, 3));
  endtask

  initial begin
    int bad = 0;
    int m, u, idx, n;
    bus.iniciar = 1'b0;
    clear_board();

    // reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset tx", bus.tx, 1);
    check("reset ocupado/pronto", {bus.ocupado, bus.pronto}, 0);
    check("reset addresses", {bus.addr_macro, bus.addr_micro}, 0);
    #20 rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.ocupado !== 1'b0 || bus.pronto !== 1'b0 ||
          bus.addr_macro !== 4'd0 || bus.addr_micro !== 4'd0) bad++;
    end
    check("idle cycles with bad outputs", bad, 0);

    // empty board
    start_frame();
    wait_done();
    check("empty row0 col0", rx_frame[0], 8'h2E);
    check("empty row8 CR", rx_frame[97], 8'h0D);
    check("empty row8 LF", rx_frame[98], 8'h0A);

    // X at (4,4), O at (8,8)
    board[4][4] = 2'b01;
    board[8][8] = 2'b10;
    start_frame();
    wait_done();
    check("byte 48 is X", rx_frame[48], 8'h58);
    check("byte 96 is O", rx_frame[96], 8'h4F);

    // '#' at a random cell
    clear_board();
    m = $urandom_range(0, 8);
    u = $urandom_range(0, 8);
    board[m][u] = 2'b11;
    idx = (3*(m/3) + u/3) * 11 + 3*(m%3) + u%3;
    start_frame();
    wait_done();
    check("hash at grid index", rx_frame[idx], 8'h23);

    // random boards
    for (int f = 0; f < 2; f++) begin
      rand_board();
      start_frame();
      wait_done();
    end

    // restart request during byte 19 is ignored
    rand_board();
    start_frame();
    wait_idx(19);
    repeat (10) @(posedge clk);
    #1 bus.iniciar = 1'b1;
    @(posedge clk); #1 bus.iniciar = 1'b0;
    wait_done();
    n = rx_total;
    repeat (300) @(posedge clk);
    check("no second frame", rx_total, n);
    check("idle after ignored restart", bus.ocupado, 0);

    // reset during a data bit of byte 10
    rand_board();
    start_frame();
    wait_idx(10);
    n = 0;
    while (bus.tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2*CPB + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset tx", bus.tx, 1);
    check("async reset ocupado", bus.ocupado, 0);
    exp_total -= exp_q.size();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    rand_board();
    start_frame();
    wait_done();

    check("addresses within 0..8", addr_bad, 0);
    check("total bytes", rx_total, exp_total);
    check("scoreboard drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
